hangman_datapath: RTL and testbench
===================================

HANGMAN_DATAPATH -- requirements
Module: hangman_datapath

Interface
REQ-001 Parameter MAX_LEN, default 16, word slots available.
REQ-002 Parameter MAX_MISS, default 6, misses that complete the gallows drawing.
REQ-003 Parameter TIMEOUT_CYC, default 50_000_000, cycles allowed per guess.
REQ-004 clk  in  1  rising-edge clock. Reset is resetn, asynchronous, active-low, and the clock is clk.
REQ-005 resetn  in  1  async active-low reset.
REQ-006 wipe  in  1  sync clear of word, mask, counters, flags.
REQ-007 ld  in  1  load-enable from control FSM.
REQ-008 load_stb  in  1  one-cycle write strobe for char_in.
REQ-009 char_in  in  5  letter code 1..26; 0 = invalid.
REQ-010 compare  in  1  guess-enable from control FSM.
REQ-011 guess_stb  in  1  one-cycle guess strobe.
REQ-012 guess_in  in  5  guessed letter code.
REQ-013 timecount  in  1  guess-timer enable.
REQ-014 word_len  out  5  stored letters, 0..MAX_LEN.
REQ-015 reveal_mask  out  MAX_LEN  bit i=1: slot i revealed.
REQ-016 busy  out  1  scan in progress.
REQ-017 result_valid  out  1  one-cycle pulse, guess result ready.
REQ-018 match  out  1  last guess hit; valid from result_valid and held until the next result_valid.
REQ-019 cont  out  1  word_len>0 and any slot below word_len unrevealed.
REQ-020 part  out  3  miss count, 0..MAX_MISS.
REQ-021 complete  out  1  part==MAX_MISS.
REQ-022 timeout  out  1  guess timer expired; sticky.

Function
REQ-023 Internal FSM states: IDLE, SCAN, RESULT. Reset state is IDLE.
REQ-024 IDLE, ld=1, load_stb=1, char_in!=0, word_len<MAX_LEN: write char_in to slot word_len, increment word_len next cycle.
REQ-025 Load strobes with char_in=0, word_len==MAX_LEN, or ld=0 are ignored, with no state change.
REQ-026 IDLE, compare=1, ld=0, guess_stb=1, guess_in!=0, word_len>0: latch guess, index:=0, go to SCAN, busy=1.
REQ-027 In any other case a guess strobe is ignored, including while busy, when guess_in=0, or when word_len=0.
REQ-028 SCAN: one slot per cycle. If slot[index]==guess, set reveal_mask[index] and set the hit flag. Leave SCAN after index word_len-1.
REQ-029 RESULT lasts one cycle: result_valid=1 and match:=hit. If the hit flag is clear and part<MAX_MISS, increment part. Then return to IDLE.
REQ-030 Latency from guess_stb to result_valid is word_len+1 cycles.
REQ-031 A guess of an already-revealed letter yields match=1 and leaves the mask unchanged.
REQ-032 part saturates at MAX_MISS. complete is asserted combinationally from part.
REQ-033 Timer: count while timecount=1 and timeout=0. On result_valid, clear the count to 0. When count reaches TIMEOUT_CYC-1, set timeout.
REQ-034 timeout clears only on wipe or reset.
REQ-035 wipe takes priority over all other inputs. On wipe: state:=IDLE, word_len:=0, mask:=0, part:=0, match:=0, timer:=0, timeout:=0. A wipe during SCAN aborts the scan with no result_valid.
REQ-036 When ld=1 and compare=1 in the same cycle, only the load action is taken.

Reset
REQ-037 resetn=0 immediately forces: state IDLE, word_len=0, reveal_mask=0, busy=0, result_valid=0, match=0, part=0, timer=0, timeout=0. Slot contents are don't-care.
REQ-038 Reset asserted mid-SCAN aborts the scan. The first cycle after release is IDLE.

Verification
REQ-039 Load H,E,L,L,O (8,5,12,12,15) with ld=1, then guess L (12) -> result_valid 6 cycles after the strobe, match=1, reveal_mask=0b01100, cont=1, part=0.
REQ-040 On the same word, guess Z (26) -> match=0, part=1, mask unchanged. Six more distinct misses -> part stays 6, complete=1.
REQ-041 Guess H,E,O after L -> mask=0b11111, cont=0. Repeating guess E -> match=1, part unchanged.
REQ-042 Load 17 letters with MAX_LEN=16 -> word_len=16, 17th ignored. char_in=0 never written.
REQ-043 TIMEOUT_CYC=10, timecount=1, no guess -> timeout=1 after 10 cycles and holds after timecount=0. A guess result before cycle 10 restarts the count.
REQ-044 wipe asserted during SCAN -> no result_valid, and all outputs return to reset values next cycle. A guess_stb while busy=1 is ignored.

Source files
------------

// File: rtl/hangman_datapath.sv
// Hangman word store, letter scan, miss counter and per-guess timer.
// Letters are loaded one per strobe; each guess scans one slot per cycle.
module hangman_datapath #(
    parameter int MAX_LEN     = 16,
    parameter int MAX_MISS    = 6,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               wipe,
    input  logic               ld,
    input  logic               load_stb,
    input  logic [4:0]         char_in,
    input  logic               compare,
    input  logic               guess_stb,
    input  logic [4:0]         guess_in,
    input  logic               timecount,
    output logic [4:0]         word_len,
    output logic [MAX_LEN-1:0] reveal_mask,
    output logic               busy,
    output logic               result_valid,
    output logic               match,
    output logic               cont,
    output logic [2:0]         part,
    output logic               complete,
    output logic               timeout
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;

    state_t        state;
    state_t        state_nx;
    logic [4:0]    slots [MAX_LEN];
    logic [LW-1:0] wlen;
    logic [IW-1:0] idx;
    logic [4:0]    guess_q;
    logic          hit;
    logic [TW-1:0] tcount;
    logic          do_load;
    logic          do_guess;
    logic          slot_hit;
    logic          last_slot;
    logic          final_hit;
    logic          pending;

    assign do_load = (state == IDLE) && ld && load_stb
                  && (char_in != 5'd0) && (wlen < LW'(MAX_LEN));
    // ld has priority: a guess is only accepted when no load is enabled.
    assign do_guess = (state == IDLE) && compare && !ld && guess_stb
                   && (guess_in != 5'd0) && (wlen != '0);
    assign slot_hit  = (slots[idx] == guess_q);
    assign last_slot = (LW'(idx) == wlen - LW'(1));
    assign final_hit = hit | slot_hit;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (do_guess) state_nx = SCAN;
            SCAN:    if (last_slot) state_nx = RESULT;
            RESULT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)   state <= IDLE;
        else if (wipe) state <= IDLE;
        else           state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (do_load && !wipe) slots[wlen[IW-1:0]] <= char_in;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wlen        <= '0;
            reveal_mask <= '0;
            idx         <= '0;
            guess_q     <= '0;
            hit         <= 1'b0;
            match       <= 1'b0;
            part        <= '0;
        end else if (wipe) begin
            wlen        <= '0;
            reveal_mask <= '0;
            idx         <= '0;
            hit         <= 1'b0;
            match       <= 1'b0;
            part        <= '0;
        end else begin
            if (do_load) begin
                wlen                     <= wlen + LW'(1);
                reveal_mask[wlen[IW-1:0]] <= 1'b0;
            end
            if (do_guess) begin
                guess_q <= guess_in;
                idx     <= '0;
                hit     <= 1'b0;
            end
            if (state == SCAN) begin
                idx <= idx + IW'(1);
                if (slot_hit) begin
                    reveal_mask[idx] <= 1'b1;
                    hit              <= 1'b1;
                end
                // Result is committed as RESULT is entered so it is
                // already stable while result_valid is high.
                if (last_slot) begin
                    match <= final_hit;
                    if (!final_hit && part < 3'(MAX_MISS))
                        part <= part + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcount  <= '0;
            timeout <= 1'b0;
        end else if (wipe) begin
            tcount  <= '0;
            timeout <= 1'b0;
        end else if (state == RESULT) begin
            tcount <= '0;
        end else if (timecount && !timeout) begin
            if (tcount == TW'(TIMEOUT_CYC - 1)) timeout <= 1'b1;
            else                                tcount  <= tcount + TW'(1);
        end
    end

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(wlen) && !reveal_mask[i]) pending = 1'b1;
        end
    end

    assign word_len     = 5'(wlen);
    assign busy         = (state == SCAN);
    assign result_valid = (state == RESULT);
    assign complete     = (part == 3'(MAX_MISS));
    assign cont         = (wlen != '0) && pending;

endmodule

// File: tb/tb_hangman_datapath.sv
// Directed bench for hangman_datapath: load, guess, misses, overflow,
// timer, wipe and reset behaviour.
module tb_hangman_datapath;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wipe = 1'b0;
    logic        ld = 1'b0;
    logic        load_stb = 1'b0;
    logic [4:0]  char_in = '0;
    logic        compare = 1'b0;
    logic        guess_stb = 1'b0;
    logic [4:0]  guess_in = '0;
    logic        timecount = 1'b0;
    logic [4:0]  word_len;
    logic [15:0] reveal_mask;
    logic        busy;
    logic        result_valid;
    logic        match;
    logic        cont;
    logic [2:0]  part;
    logic        complete;
    logic        timeout;

    int n_cmp = 0;
    int n_bad = 0;

    hangman_datapath #(
        .MAX_LEN(16), .MAX_MISS(6), .TIMEOUT_CYC(10)
    ) dut (
        .clk(clk), .resetn(resetn), .wipe(wipe), .ld(ld),
        .load_stb(load_stb), .char_in(char_in), .compare(compare),
        .guess_stb(guess_stb), .guess_in(guess_in),
        .timecount(timecount), .word_len(word_len),
        .reveal_mask(reveal_mask), .busy(busy),
        .result_valid(result_valid), .match(match), .cont(cont),
        .part(part), .complete(complete), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wipe();
        wipe = 1'b1;
        tick();
        wipe = 1'b0;
    endtask

    task automatic load(input logic [4:0] c, input logic en);
        ld = en; load_stb = 1'b1; char_in = c;
        tick();
        ld = 1'b0; load_stb = 1'b0; char_in = '0;
    endtask

    task automatic load_hello();
        load(5'd8, 1'b1); load(5'd5, 1'b1); load(5'd12, 1'b1);
        load(5'd12, 1'b1); load(5'd15, 1'b1);
    endtask

    task automatic guess(input logic [4:0] g, output int lat,
                         output logic m);
        compare = 1'b1; guess_stb = 1'b1; guess_in = g;
        tick();
        guess_stb = 1'b0; compare = 1'b0; guess_in = '0;
        lat = 1;
        while (!result_valid && lat < 40) begin
            tick();
            lat++;
        end
        m = match;
        tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        n_cmp++;
        if ({word_len, reveal_mask, busy, result_valid, match, part,
             timeout, complete, cont} !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got wl=%0d mask=%h busy=%b rv=%b m=%b part=%0d to=%b cpl=%b cont=%b want all 0",
                     word_len, reveal_mask, busy, result_valid, match,
                     part, timeout, complete, cont);
        end
        resetn = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || word_len !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_release: got busy=%b wl=%0d want 0/0",
                     busy, word_len);
        end
    endtask

    task automatic test_load_guess();
        int lat; logic m;
        do_wipe();
        load_hello();
        n_cmp++;
        if (word_len !== 5'd5 || cont !== 1'b1) begin
            n_bad++;
            $display("FAIL load_hello: got wl=%0d cont=%b want 5/1",
                     word_len, cont);
        end
        guess(5'd12, lat, m);
        n_cmp++;
        if (lat !== 6) begin
            n_bad++;
            $display("FAIL guess_latency: got %0d want 6", lat);
        end
        n_cmp++;
        if (m !== 1'b1 || reveal_mask !== 16'h000C || cont !== 1'b1
            || part !== 3'd0) begin
            n_bad++;
            $display("FAIL guess_L: got m=%b mask=%h cont=%b part=%0d want 1/000c/1/0",
                     m, reveal_mask, cont, part);
        end
    endtask

    task automatic test_miss();
        int lat; logic m;
        logic [4:0] misses [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7};
        guess(5'd26, lat, m);
        n_cmp++;
        if (m !== 1'b0 || part !== 3'd1 || reveal_mask !== 16'h000C
            || complete !== 1'b0) begin
            n_bad++;
            $display("FAIL miss_Z: got m=%b part=%0d mask=%h cpl=%b want 0/1/000c/0",
                     m, part, reveal_mask, complete);
        end
        foreach (misses[i]) guess(misses[i], lat, m);
        n_cmp++;
        if (part !== 3'd6 || complete !== 1'b1 || m !== 1'b0) begin
            n_bad++;
            $display("FAIL miss_saturate: got part=%0d cpl=%b m=%b want 6/1/0",
                     part, complete, m);
        end
    endtask

    task automatic test_reveal();
        int lat; logic m;
        do_wipe();
        load_hello();
        guess(5'd12, lat, m);
        guess(5'd8, lat, m);
        guess(5'd5, lat, m);
        guess(5'd15, lat, m);
        n_cmp++;
        if (reveal_mask !== 16'h001F || cont !== 1'b0) begin
            n_bad++;
            $display("FAIL reveal_all: got mask=%h cont=%b want 001f/0",
                     reveal_mask, cont);
        end
        guess(5'd5, lat, m);
        n_cmp++;
        if (m !== 1'b1 || part !== 3'd0 || reveal_mask !== 16'h001F) begin
            n_bad++;
            $display("FAIL repeat_E: got m=%b part=%0d mask=%h want 1/0/001f",
                     m, part, reveal_mask);
        end
    endtask

    task automatic test_overflow();
        int lat; logic m;
        do_wipe();
        load(5'd0, 1'b1);
        load(5'd5, 1'b0);
        n_cmp++;
        if (word_len !== 5'd0) begin
            n_bad++;
            $display("FAIL ignored_loads: got wl=%0d want 0", word_len);
        end
        for (int i = 1; i <= 17; i++) load(5'(i), 1'b1);
        n_cmp++;
        if (word_len !== 5'd16) begin
            n_bad++;
            $display("FAIL overflow_len: got %0d want 16", word_len);
        end
        guess(5'd17, lat, m);
        n_cmp++;
        if (m !== 1'b0 || lat !== 17) begin
            n_bad++;
            $display("FAIL no_17th: got m=%b lat=%0d want 0/17", m, lat);
        end
        guess(5'd16, lat, m);
        n_cmp++;
        if (m !== 1'b1 || reveal_mask !== 16'h8000) begin
            n_bad++;
            $display("FAIL last_slot: got m=%b mask=%h want 1/8000",
                     m, reveal_mask);
        end
    endtask

    task automatic test_ignored();
        do_wipe();
        compare = 1'b1; guess_stb = 1'b1; guess_in = 5'd3;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL guess_empty: got busy=%b want 0", busy);
        end
        ld = 1'b1; load_stb = 1'b1; char_in = 5'd3;
        tick();
        ld = 1'b0; load_stb = 1'b0;
        n_cmp++;
        if (word_len !== 5'd1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ld_over_compare: got wl=%0d busy=%b want 1/0",
                     word_len, busy);
        end
        guess_in = 5'd0;
        tick();
        guess_stb = 1'b0; compare = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL guess_zero: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_timeout();
        int lat; logic m;
        do_wipe();
        timecount = 1'b1;
        repeat (9) tick();
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_early: got %b want 0", timeout);
        end
        tick();
        n_cmp++;
        if (timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_set: got %b want 1", timeout);
        end
        timecount = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_sticky: got %b want 1", timeout);
        end
        do_wipe();
        load_hello();
        timecount = 1'b1;
        guess(5'd12, lat, m);
        repeat (9) tick();
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timer_restart: got %b want 0", timeout);
        end
        tick();
        n_cmp++;
        if (timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL timer_after_restart: got %b want 1", timeout);
        end
        timecount = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat; int seen;
        do_wipe();
        load_hello();
        compare = 1'b1; guess_stb = 1'b1; guess_in = 5'd12;
        tick();
        guess_in = 5'd8;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_set: got %b want 1", busy);
        end
        tick();
        guess_stb = 1'b0; compare = 1'b0; guess_in = '0;
        lat = 2;
        while (!result_valid && lat < 40) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (lat !== 6) begin
            n_bad++;
            $display("FAIL busy_latency: got %0d want 6", lat);
        end
        seen = 0;
        repeat (10) begin
            tick();
            if (result_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0 || reveal_mask !== 16'h000C) begin
            n_bad++;
            $display("FAIL busy_guess_ignored: got extra=%0d mask=%h want 0/000c",
                     seen, reveal_mask);
        end
    endtask

    task automatic test_wipe_scan();
        int lat; int seen; logic m;
        do_wipe();
        load_hello();
        guess(5'd12, lat, m);
        guess(5'd26, lat, m);
        guess(5'd5, lat, m);
        compare = 1'b1; guess_stb = 1'b1; guess_in = 5'd8;
        tick();
        guess_stb = 1'b0; compare = 1'b0;
        tick();
        wipe = 1'b1;
        tick();
        wipe = 1'b0;
        n_cmp++;
        if ({word_len, reveal_mask, busy, result_valid, match, part,
             timeout} !== 29'd0) begin
            n_bad++;
            $display("FAIL wipe_scan: got wl=%0d mask=%h busy=%b rv=%b m=%b part=%0d to=%b want all 0",
                     word_len, reveal_mask, busy, result_valid, match,
                     part, timeout);
        end
        seen = 0;
        repeat (8) begin
            tick();
            if (result_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL wipe_no_result: got %0d pulses want 0", seen);
        end
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        do_wipe();
        load_hello();
        compare = 1'b1; guess_stb = 1'b1; guess_in = 5'd12;
        tick();
        guess_stb = 1'b0; compare = 1'b0;
        tick();
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || word_len !== 5'd0 || reveal_mask !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_async: got busy=%b wl=%0d mask=%h want 0/0/0",
                     busy, word_len, reveal_mask);
        end
        tick();
        resetn = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            if (result_valid || busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL reset_abort: got %0d active cycles want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_load_guess();
        test_miss();
        test_reveal();
        test_overflow();
        test_ignored();
        test_timeout();
        test_back_to_back();
        test_wipe_scan();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
